// File: rtl/add_pipe.sv
// add_pipe: WIDTH_P-bit adder/subtractor whose carry chain is cut into STAGES_P registered slices,
// with valid/ready flow control on both sides. Define ADD_PIPE_OVERFLOW_EN to add the ovf_o output.
module add_pipe #(
  parameter int WIDTH_P  = 32,
  parameter int STAGES_P = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH_P-1:0] a_i,
  input  logic [WIDTH_P-1:0] b_i,
  input  logic               cin_i,
  input  logic               sub_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH_P-1:0] sum_o,
`ifdef ADD_PIPE_OVERFLOW_EN
  output logic               carry_o,
  output logic               ovf_o
`else
  output logic               carry_o
`endif
);

  localparam int SLICE_W = (STAGES_P < 1) ? WIDTH_P : WIDTH_P / STAGES_P;
  localparam int OPS_N   = (STAGES_P > 1) ? STAGES_P - 1 : 1;

  if (STAGES_P < 1) begin : g_bad_stages
    $fatal(1, "add_pipe: STAGES_P must be at least 1");
  end else if ((WIDTH_P % STAGES_P) != 0) begin : g_bad_split
    $fatal(1, "add_pipe: STAGES_P must divide WIDTH_P");
  end

  // Per-stage state: valid, slice carry, partially assembled sum.
  logic [STAGES_P-1:0] v_q;
  logic [STAGES_P-1:0] c_q;
  logic [WIDTH_P-1:0]  sum_q [STAGES_P];

  // Operands still waiting for their upper slices, right-aligned so every stage adds bits [SLICE_W-1:0].
  logic [WIDTH_P-1:0]  op_a_q [OPS_N];
  logic [WIDTH_P-1:0]  op_b_q [OPS_N];

  // What each stage sees on its input side, and what it would capture.
  logic [STAGES_P-1:0] src_v;
  logic [STAGES_P-1:0] src_c;
  logic [WIDTH_P-1:0]  src_a   [STAGES_P];
  logic [WIDTH_P-1:0]  src_b   [STAGES_P];
  logic [WIDTH_P-1:0]  src_sum [STAGES_P];
  logic [STAGES_P-1:0] nxt_c;
  logic [WIDTH_P-1:0]  nxt_sum [STAGES_P];
  logic [STAGES_P-1:0] load;

  // NOTE: every output of this block is assigned on every pass, so no latch can be inferred.
  always_comb begin
    logic [SLICE_W-1:0] slice_s;
    slice_s    = '0;
    src_v[0]   = valid_i;
    src_a[0]   = a_i;
    src_b[0]   = sub_i ? ~b_i : b_i;
    src_c[0]   = sub_i | cin_i;
    src_sum[0] = '0;
    for (int k = 1; k < STAGES_P; k++) begin
      src_v[k]   = v_q[k-1];
      src_a[k]   = op_a_q[k-1];
      src_b[k]   = op_b_q[k-1];
      src_c[k]   = c_q[k-1];
      src_sum[k] = sum_q[k-1];
    end
    for (int k = 0; k < STAGES_P; k++) begin
      {nxt_c[k], slice_s} = {1'b0, src_a[k][SLICE_W-1:0]} + {1'b0, src_b[k][SLICE_W-1:0]}
                          + (SLICE_W+1)'(src_c[k]);
      // New slice enters at the top; after the last stage slice 0 has been shifted down to bit 0.
      nxt_sum[k] = (src_sum[k] >> SLICE_W) | (WIDTH_P'(slice_s) << (WIDTH_P - SLICE_W));
    end
  end

  // A stage may load when it is empty or its occupant moves on this cycle (bubble collapsing).
  always_comb begin
    load[STAGES_P-1] = !v_q[STAGES_P-1] || ready_i;
    for (int k = STAGES_P - 2; k >= 0; k--) begin
      load[k] = !v_q[k] || load[k+1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages sample pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the data registers are reset too, because sum_o/carry_o must read 0 out of reset.
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < STAGES_P; k++) sum_q[k] <= '0;
      for (int k = 0; k < OPS_N; k++) begin
        op_a_q[k] <= '0;
        op_b_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES_P; k++) begin
        if (load[k]) begin
          v_q[k] <= src_v[k];
          // Data only moves with a real transaction, which keeps idle toggling down.
          if (src_v[k]) begin
            c_q[k]   <= nxt_c[k];
            sum_q[k] <= nxt_sum[k];
          end
        end
      end
      for (int k = 0; k < STAGES_P - 1; k++) begin
        if (load[k] && src_v[k]) begin
          op_a_q[k] <= src_a[k] >> SLICE_W;
          op_b_q[k] <= src_b[k] >> SLICE_W;
        end
      end
    end
  end

`ifdef ADD_PIPE_OVERFLOW_EN
  logic ovf_q;
  logic msb_cin;

  // Carry into the MSB recovered from the sum bit: s = a ^ b ^ cin.
  assign msb_cin = src_a[STAGES_P-1][SLICE_W-1] ^ src_b[STAGES_P-1][SLICE_W-1]
                 ^ nxt_sum[STAGES_P-1][WIDTH_P-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else if (load[STAGES_P-1] && src_v[STAGES_P-1]) begin
      ovf_q <= msb_cin ^ nxt_c[STAGES_P-1];
    end
  end

  assign ovf_o = ovf_q;
`endif

  assign ready_o = load[0];
  assign valid_o = v_q[STAGES_P-1];
  assign sum_o   = sum_q[STAGES_P-1];
  assign carry_o = c_q[STAGES_P-1];

endmodule
